tinker_fetch_queue: RTL and testbench

Instruction fetch front end for the Tinker core. It owns the fetch PC, issues 32-bit instruction reads to a variable-latency, in-order instruction memory port, and buffers the returned words with their PCs in a small FIFO. The decoder consumes the FIFO through a valid/ready handshake. The execute stage steers the queue with a redirect (branch, call or return target), which flushes buffered and in-flight fetches.

---
 rtl/tinker_fetch_queue_pkg.sv | 24 ++
 rtl/tinker_fetch_queue_if.sv | 47 ++++
 rtl/tinker_fetch_queue_fifo.sv | 63 ++++++
 rtl/tinker_fetch_queue.sv | 110 +++++++++++
 tb/tb_tinker_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tinker_fetch_pkg
// Brief    : Shared types and constants for the Tinker fetch queue.
// Revision : 1.0
// ============================================================================
package tinker_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          ADDR_W           = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h2000;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/tinker_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : tinker_fetch_queue_if
// Brief    : Memory, redirect and decoder-side signals of the fetch queue.
// Revision : 1.0
// ============================================================================
interface tinker_fetch_queue_if
    import tinker_fetch_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [ADDR_W-1:0]    imem_req_addr;
    logic                 imem_rsp_valid;
    logic [INSTR_W-1:0]   imem_rsp_data;
    logic                 redirect_valid;
    logic [ADDR_W-1:0]    redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic [ADDR_W-1:0]    out_pc;
    logic                 fault;
    logic [c_CNT_W-1:0]   occupancy;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        output fault, occupancy
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        input  fault, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/tinker_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tinker_instr_fifo
// Brief    : Fetched-instruction FIFO with synchronous flush and count output.
// Revision : 1.0
// ============================================================================
module tinker_instr_fifo
    import tinker_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int            c_AW    = $clog2(DEPTH);
    localparam int            c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);
    assign o_valid  = (r_count != '0);
    assign o_count  = r_count;
    assign o_head   = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_CW'(i_push) - c_CW'(w_do_pop);
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (reset && !i_flush && i_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset && !i_flush && i_push && !w_do_pop)
            assert (r_count != c_FULL) else $error("tinker_instr_fifo overflow");
    end

endmodule
`default_nettype wire

// File: rtl/tinker_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tinker_fetch_queue
// Brief    : Fetch PC, request credit/drop tracking and redirect/fault FSM.
// Revision : 1.0
// ============================================================================
module tinker_fetch_queue
    import tinker_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    tinker_fetch_queue_if.master  bus
);
    localparam int                 c_CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W:0]   c_DEPTH_X = (c_CNT_W + 1)'(DEPTH);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [ADDR_W-3:0]   r_fetch_word;
    logic [ADDR_W-1:0]   r_rsp_pc;
    logic [c_CNT_W-1:0]  r_pend;
    logic [c_CNT_W-1:0]  r_drop;
    logic [c_CNT_W-1:0]  w_pend_next;
    logic [c_CNT_W-1:0]  w_live;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W:0]    w_credit;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_rsp_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;
    fetch_entry_t        w_push_data;
    fetch_entry_t        w_head;

    // Credit counts buffered plus live in-flight words so a live response always has room.
    assign w_live      = r_pend - r_drop;
    assign w_credit    = {1'b0, w_count} + {1'b0, w_live};
    assign w_req_valid = (r_state == FETCH) && (w_credit < c_DEPTH_X) && (r_pend < c_DEPTH);
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp_fire  = bus.imem_rsp_valid;
    assign w_push      = w_rsp_fire && (r_drop == '0) && !bus.redirect_valid;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_pend_next = r_pend + c_CNT_W'(w_req_fire) - c_CNT_W'(w_rsp_fire);
    assign w_push_data = '{instr: bus.imem_rsp_data, pc: r_rsp_pc};

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= FETCH;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.redirect_valid)
            w_state_next = (bus.redirect_pc[1:0] == 2'b00) ? FETCH : FAULT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_word <= RESET_PC[ADDR_W-1:2];
            r_rsp_pc     <= RESET_PC;
            r_pend       <= '0;
            r_drop       <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (bus.redirect_valid) begin
                r_drop       <= w_pend_next;
                r_fetch_word <= bus.redirect_pc[ADDR_W-1:2];
                r_rsp_pc     <= bus.redirect_pc;
            end else begin
                if (w_req_fire)
                    r_fetch_word <= r_fetch_word + 1'b1;
                if (w_push)
                    r_rsp_pc <= r_rsp_pc + 64'd4;
                if (w_rsp_fire && (r_drop != '0))
                    r_drop <= r_drop - 1'b1;
            end
        end
    end

    tinker_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_out_valid),
        .o_count     (w_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = {r_fetch_word, 2'b00};
    assign bus.out_valid      = w_out_valid;
    assign bus.out_instr      = w_head.instr;
    assign bus.out_pc         = w_head.pc;
    assign bus.fault          = (r_state == FAULT);
    assign bus.occupancy      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_tinker_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinker_fetch_queue
// Brief    : Directed bench for tinker_fetch_queue with an in-order memory model.
// Revision : 1.0
// ============================================================================
module tb_tinker_fetch_queue;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        ordy;
        logic        chk;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_ov;
        logic [63:0] exp_pc;
        logic [2:0]  exp_occ;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    logic   clk;
    logic   reset_n;
    int     checks;
    int     failures;
    int     lat;
    int     cyc;
    int     nreq;
    mreq_t  mq[$];
    vec_t   vt[$];

    tinker_fetch_queue_if #(.DEPTH(4)) bus ();

    tinker_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h2000)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memw(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mkv(input logic r, input logic rdy, input logic ordy, input logic c,
                                 input logic rv, input logic [63:0] a, input logic ov,
                                 input logic [63:0] pc, input logic [2:0] occ);
        vec_t v;
        v.rst_n = r;  v.rdy = rdy; v.ordy = ordy; v.chk = c;
        v.exp_rv = rv; v.exp_addr = a; v.exp_ov = ov; v.exp_pc = pc; v.exp_occ = occ;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock edge plus the memory model: responses return in order, lat cycles after the request.
    task automatic tick();
        logic        fire;
        logic [63:0] fa;
        logic        rf;
        logic        rn;
        fire = bus.imem_req_valid & bus.imem_req_ready & reset_n;
        fa   = bus.imem_req_addr;
        rf   = bus.imem_rsp_valid;
        rn   = reset_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!rn) begin
            mq.delete();
            nreq = 0;
        end else begin
            if (rf && mq.size() > 0)
                mq.delete(0);
            if (fire) begin
                mq.push_back('{addr: fa, due: cyc + lat});
                nreq++;
            end
        end
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memw(mq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        #1;
        chk({tag, "_req_valid"}, {63'd0, bus.imem_req_valid}, 64'd1);
        chk({tag, "_req_addr"}, bus.imem_req_addr, 64'h2000);
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_fault"}, {63'd0, bus.fault}, 64'd0);
        chk({tag, "_occupancy"}, {61'd0, bus.occupancy}, 64'd0);
    endtask

    // Waits a bounded number of cycles for the next decoder-visible entry and checks it.
    task automatic expect_first_out(input string tag, input logic [63:0] pc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            #1;
            if (bus.out_valid)
                got = 1'b1;
            else
                tick();
        end
        chk({tag, "_out_seen"}, {63'd0, got}, 64'd1);
        if (got) begin
            chk({tag, "_out_pc"}, bus.out_pc, pc);
            chk({tag, "_out_instr"}, {32'd0, bus.out_instr}, {32'd0, memw(pc)});
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; nreq = 0; lat = 1;
        reset_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;

        // Streaming at latency 1, then back-pressure with a single pop.
        vt.push_back(mkv(0, 1, 1, 0, 0, 64'h0,    0, 64'h0,    0));
        vt.push_back(mkv(1, 1, 1, 1, 1, 64'h2000, 0, 64'h0,    0));
        vt.push_back(mkv(1, 1, 1, 1, 1, 64'h2004, 0, 64'h0,    0));
        vt.push_back(mkv(1, 1, 1, 1, 1, 64'h2008, 1, 64'h2000, 1));
        vt.push_back(mkv(1, 1, 1, 1, 1, 64'h200c, 1, 64'h2004, 1));
        vt.push_back(mkv(1, 1, 1, 1, 1, 64'h2010, 1, 64'h2008, 1));
        vt.push_back(mkv(0, 1, 0, 0, 0, 64'h0,    0, 64'h0,    0));
        vt.push_back(mkv(1, 1, 0, 1, 1, 64'h2000, 0, 64'h0,    0));
        vt.push_back(mkv(1, 1, 0, 1, 1, 64'h2004, 0, 64'h0,    0));
        vt.push_back(mkv(1, 1, 0, 1, 1, 64'h2008, 1, 64'h2000, 1));
        vt.push_back(mkv(1, 1, 0, 1, 1, 64'h200c, 1, 64'h2000, 2));
        vt.push_back(mkv(1, 1, 0, 1, 0, 64'h0,    1, 64'h2000, 3));
        vt.push_back(mkv(1, 1, 0, 1, 0, 64'h0,    1, 64'h2000, 4));
        vt.push_back(mkv(1, 1, 1, 1, 0, 64'h0,    1, 64'h2000, 4));
        vt.push_back(mkv(1, 1, 0, 1, 1, 64'h2010, 1, 64'h2004, 3));
        vt.push_back(mkv(1, 1, 0, 1, 0, 64'h0,    1, 64'h2004, 3));
        vt.push_back(mkv(1, 1, 0, 1, 0, 64'h0,    1, 64'h2004, 4));

        foreach (vt[i]) begin
            reset_n            = vt[i].rst_n;
            bus.imem_req_ready = vt[i].rdy;
            bus.out_ready      = vt[i].ordy;
            bus.redirect_valid = 1'b0;
            #1;
            if (vt[i].chk) begin
                chk($sformatf("vec%0d_req_valid", i), {63'd0, bus.imem_req_valid}, {63'd0, vt[i].exp_rv});
                if (vt[i].exp_rv)
                    chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vt[i].exp_addr);
                chk($sformatf("vec%0d_out_valid", i), {63'd0, bus.out_valid}, {63'd0, vt[i].exp_ov});
                if (vt[i].exp_ov) begin
                    chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vt[i].exp_pc);
                    chk($sformatf("vec%0d_out_instr", i), {32'd0, bus.out_instr}, {32'd0, memw(vt[i].exp_pc)});
                end
                chk($sformatf("vec%0d_occupancy", i), {61'd0, bus.occupancy}, {61'd0, vt[i].exp_occ});
                chk($sformatf("vec%0d_fault", i), {63'd0, bus.fault}, 64'd0);
            end
            tick();
        end
        chk("bp_request_count", 64'(nreq), 64'd5);

        // Redirect with three requests in flight at latency 3.
        lat = 3;
        bus.out_ready = 1'b1;
        do_reset();
        #1; tick();
        #1; tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3000;
        #1;
        chk("rd_pre_req_addr", bus.imem_req_addr, 64'h2008);
        tick();
        bus.redirect_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rd_c%0d_req_addr", c), bus.imem_req_addr, 64'h3000 + 64'(4 * c));
            chk($sformatf("rd_c%0d_out_valid", c), {63'd0, bus.out_valid}, 64'd0);
            tick();
        end
        #1;
        chk("rd_first_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("rd_first_out_pc", bus.out_pc, 64'h3000);
        chk("rd_first_out_instr", {32'd0, bus.out_instr}, {32'd0, memw(64'h3000)});

        // Misaligned target halts fetching until an aligned redirect.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3002;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("flt_c%0d_fault", c), {63'd0, bus.fault}, 64'd1);
            chk($sformatf("flt_c%0d_req_valid", c), {63'd0, bus.imem_req_valid}, 64'd0);
            chk($sformatf("flt_c%0d_out_valid", c), {63'd0, bus.out_valid}, 64'd0);
            chk($sformatf("flt_c%0d_occupancy", c), {61'd0, bus.occupancy}, 64'd0);
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h4000;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("flt_exit_fault", {63'd0, bus.fault}, 64'd0);
        chk("flt_exit_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("flt_exit_req_addr", bus.imem_req_addr, 64'h4000);
        expect_first_out("flt_exit", 64'h4000);

        // Redirect coinciding with a pop and a live response.
        lat = 1;
        bus.out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            #1; tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h5000;
        #1;
        chk("rpr_pre_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("rpr_pre_out_pc", bus.out_pc, 64'h2008);
        chk("rpr_pre_occupancy", {61'd0, bus.occupancy}, 64'd1);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rpr_post_occupancy", {61'd0, bus.occupancy}, 64'd0);
        chk("rpr_post_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rpr_post_req_addr", bus.imem_req_addr, 64'h5000);
        expect_first_out("rpr", 64'h5000);

        // Reset mid-stream, then reset out of FAULT.
        for (int c = 0; c < 2; c++) begin
            #1; tick();
        end
        do_reset();
        chk_reset_state("rst_stream");
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h6001;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_fault_set", {63'd0, bus.fault}, 64'd1);
        do_reset();
        chk_reset_state("rst_fault");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
